// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, arbiter FSM states and opcode legality check
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_CBZ  = 4'b0111;
    localparam logic [3:0] OP_SUB  = 4'b1010;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_ORR  = 4'b0100;
    localparam logic [3:0] OP_EOR  = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_NAND = 4'b1100;
    localparam logic [3:0] OP_MOV  = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXEC    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    function automatic logic isLegalOp(input logic [3:0] op);
        case (op)
            OP_ADD, OP_CBZ, OP_SUB, OP_AND, OP_ORR,
            OP_EOR, OP_NOR, OP_NAND, OP_MOV: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter favouring the requester not granted last
module rr_arbiter2 (
    input  logic valid0,
    input  logic valid1,
    input  logic lastGrant,
    output logic grant,
    output logic id
);

    always_comb begin
        grant = valid0 | valid1;
        if (valid0 && valid1) begin
            id = ~lastGrant;
        end else begin
            id = valid1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one registered ALU between the execute stage and the branch unit
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  reqValid0,
    output logic                  reqReady0,
    input  logic [OP_WIDTH-1:0]   reqOpcode0,
    input  logic [DATA_WIDTH-1:0] reqA0,
    input  logic [DATA_WIDTH-1:0] reqB0,
    input  logic                  reqValid1,
    output logic                  reqReady1,
    input  logic [OP_WIDTH-1:0]   reqOpcode1,
    input  logic [DATA_WIDTH-1:0] reqA1,
    input  logic [DATA_WIDTH-1:0] reqB1,
    output logic                  respValid,
    input  logic                  respReady,
    output logic                  respId,
    output logic [DATA_WIDTH-1:0] respResult,
    output logic                  respZero,
    output logic                  respError,
    output logic [DATA_WIDTH-1:0] aluInOne,
    output logic [DATA_WIDTH-1:0] aluInTwo,
    output logic [OP_WIDTH-1:0]   aluOpcode,
    input  logic [DATA_WIDTH-1:0] aluResult,
    input  logic                  aluZero,
    output logic                  busy
);

    state_t                state;
    state_t                next_state;
    logic                  last_grant;
    logic                  arb_grant;
    logic                  arb_id;
    logic                  accept;
    logic                  alu_active;
    logic                  op_id;
    logic [OP_WIDTH-1:0]   op_reg;
    logic [DATA_WIDTH-1:0] a_reg;
    logic [DATA_WIDTH-1:0] b_reg;

    rr_arbiter2 u_arb (
        .valid0    (reqValid0),
        .valid1    (reqValid1),
        .lastGrant (last_grant),
        .grant     (arb_grant),
        .id        (arb_id)
    );

    assign accept    = (state == ST_IDLE) && arb_grant;
    assign reqReady0 = accept && !arb_id;
    assign reqReady1 = accept && arb_id;
    assign respValid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (arb_grant) next_state = ST_EXEC;
            ST_EXEC:    next_state = ST_CAPTURE;
            ST_CAPTURE: next_state = ST_RESP;
            ST_RESP:    if (respReady) next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // Operands stay staged from accept until the ALU result is captured.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            last_grant <= 1'b1;
            op_id      <= 1'b0;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            respResult <= '0;
            respZero   <= 1'b0;
            respError  <= 1'b0;
            respId     <= 1'b0;
        end else begin
            if (accept) begin
                op_id      <= arb_id;
                last_grant <= arb_id;
                op_reg     <= arb_id ? reqOpcode1 : reqOpcode0;
                a_reg      <= arb_id ? reqA1 : reqA0;
                b_reg      <= arb_id ? reqB1 : reqB0;
            end
            if (state == ST_CAPTURE) begin
                respResult <= aluResult;
                respZero   <= aluZero;
                respId     <= op_id;
                respError  <= !isLegalOp(op_reg);
            end
        end
    end

    always_comb begin
        alu_active = (state == ST_EXEC) || (state == ST_CAPTURE);
        aluInOne   = alu_active ? a_reg  : '0;
        aluInTwo   = alu_active ? b_reg  : '0;
        aluOpcode  = alu_active ? op_reg : '0;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a behavioural registered ALU
module tb_alu_arbiter;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    typedef struct {
        logic        id;
        logic [31:0] result;
        logic        zero;
        logic        err;
    } exp_t;

    localparam logic [3:0] LEGAL [9] = '{4'b0010, 4'b0111, 4'b1010, 4'b0110, 4'b0100,
                                         4'b1001, 4'b0101, 4'b1100, 4'b1101};

    logic        clock, resetN;
    logic        reqValid0, reqReady0, reqValid1, reqReady1;
    logic [3:0]  reqOpcode0, reqOpcode1;
    logic [31:0] reqA0, reqB0, reqA1, reqB1;
    logic        respValid, respReady, respId, respZero, respError;
    logic [31:0] respResult;
    logic [31:0] aluInOne, aluInTwo, aluResult;
    logic [3:0]  aluOpcode;
    logic        aluZero, busy;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    op_t  q0[$];
    op_t  q1[$];
    int   acc[$];
    logic rr0, rr1, rv_seen;
    logic [31:0] res_seen;
    logic [3:0]  aop_seen;

    alu_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(4)) dut (
        .clock(clock), .resetN(resetN),
        .reqValid0(reqValid0), .reqReady0(reqReady0), .reqOpcode0(reqOpcode0),
        .reqA0(reqA0), .reqB0(reqB0),
        .reqValid1(reqValid1), .reqReady1(reqReady1), .reqOpcode1(reqOpcode1),
        .reqA1(reqA1), .reqB1(reqB1),
        .respValid(respValid), .respReady(respReady), .respId(respId),
        .respResult(respResult), .respZero(respZero), .respError(respError),
        .aluInOne(aluInOne), .aluInTwo(aluInTwo), .aluOpcode(aluOpcode),
        .aluResult(aluResult), .aluZero(aluZero), .busy(busy)
    );

    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        case (op)
            4'b0010: return a + b;
            4'b1010: return a - b;
            4'b0110: return a & b;
            4'b0100: return a | b;
            4'b1001: return a ^ b;
            4'b0101: return ~(a | b);
            4'b1100: return ~(a & b);
            4'b1101: return a;
            4'b0111: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic legal(input logic [3:0] op);
        for (int i = 0; i < 9; i++) begin
            if (LEGAL[i] == op) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic exp_t make_exp(input logic id, input op_t o);
        exp_t e;
        e.id     = id;
        e.result = alu_model(o.op, o.a, o.b);
        e.zero   = (o.a == 32'd0);
        e.err    = !legal(o.op);
        return e;
    endfunction

    always @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            aluResult <= 32'd0;
            aluZero   <= 1'b0;
        end else begin
            aluResult <= alu_model(aluOpcode, aluInOne, aluInTwo);
            aluZero   <= (aluInOne == 32'd0);
        end
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample on the falling edge, retire any response, then step past the next rising edge.
    task automatic cyc();
        exp_t e;
        @(negedge clock);
        rr0 = reqReady0;
        rr1 = reqReady1;
        rv_seen = respValid;
        res_seen = respResult;
        aop_seen = aluOpcode;
        if (respValid && respReady) begin
            if (sb.size() == 0) begin
                chk("resp_unexpected", respValid, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("resp_id", respId, e.id);
                chk("resp_result", respResult, e.result);
                chk("resp_zero", respZero, e.zero);
                chk("resp_error", respError, e.err);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic run_pair();
        acc.delete();
        for (int i = 0; i < 200 && (q0.size() > 0 || q1.size() > 0); i++) begin
            reqValid0 = (q0.size() > 0);
            if (q0.size() > 0) begin
                reqOpcode0 = q0[0].op; reqA0 = q0[0].a; reqB0 = q0[0].b;
            end
            reqValid1 = (q1.size() > 0);
            if (q1.size() > 0) begin
                reqOpcode1 = q1[0].op; reqA1 = q1[0].a; reqB1 = q1[0].b;
            end
            cyc();
            if (rr0) begin
                sb.push_back(make_exp(1'b0, q0[0]));
                void'(q0.pop_front());
                acc.push_back(0);
            end
            if (rr1) begin
                sb.push_back(make_exp(1'b1, q1[0]));
                void'(q1.pop_front());
                acc.push_back(1);
            end
        end
        reqValid0 = 1'b0;
        reqValid1 = 1'b0;
        chk("pair_accept_timeout", q0.size() + q1.size(), 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() > 0; i++) cyc();
        chk("drain_empty", sb.size(), 0);
    endtask

    task automatic do_reset();
        reqValid0 = 1'b0;
        reqValid1 = 1'b0;
        resetN = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        resetN = 1'b1;
        sb.delete();
    endtask

    initial begin
        resetN = 1'b0;
        reqValid0 = 1'b0; reqOpcode0 = 4'd0; reqA0 = 32'd0; reqB0 = 32'd0;
        reqValid1 = 1'b0; reqOpcode1 = 4'd0; reqA1 = 32'd0; reqB1 = 32'd0;
        respReady = 1'b1;

        // Reset state
        @(posedge clock);
        #1;
        chk("rst_respValid", respValid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_aluOpcode", aluOpcode, 4'b0000);
        chk("rst_aluInOne", aluInOne, 32'd0);
        chk("rst_aluInTwo", aluInTwo, 32'd0);
        chk("rst_respResult", respResult, 32'd0);
        chk("rst_respId", respId, 1'b0);
        chk("rst_respError", respError, 1'b0);
        chk("rst_respZero", respZero, 1'b0);
        chk("rst_reqReady0", reqReady0, 1'b0);
        chk("rst_reqReady1", reqReady1, 1'b0);
        @(posedge clock);
        #1;
        resetN = 1'b1;

        // Single ADD from requester 0 with latency checks
        reqValid0 = 1'b1; reqOpcode0 = 4'b0010; reqA0 = 32'd15; reqB0 = 32'd15;
        cyc();
        chk("t1_ready0", rr0, 1'b1);
        chk("t1_ready1", rr1, 1'b0);
        if (rr0) sb.push_back(make_exp(1'b0, '{4'b0010, 32'd15, 32'd15}));
        cyc();
        reqValid0 = 1'b0;
        chk("t1_ready0_once", rr0, 1'b0);
        chk("t1_valid_edge1", rv_seen, 1'b0);
        chk("t1_exec_opcode", aop_seen, 4'b0010);
        cyc();
        chk("t1_valid_edge2_pre", rv_seen, 1'b0);
        cyc();
        chk("t1_valid_after_2_edges", rv_seen, 1'b1);
        chk("t1_drained", sb.size(), 0);
        cyc();
        chk("t1_valid_dropped", rv_seen, 1'b0);

        // Both valid from reset: requester 0 first
        do_reset();
        q0.push_back('{4'b1010, 32'd10, 32'd5});
        q1.push_back('{4'b1001, 32'd5, 32'd10});
        run_pair();
        chk("t2_order_n", acc.size(), 2);
        if (acc.size() == 2) begin
            chk("t2_first", acc[0], 0);
            chk("t2_second", acc[1], 1);
        end
        drain();

        // Fairness: both held valid for four operations
        for (int i = 0; i < 2; i++) begin
            q0.push_back('{LEGAL[$urandom_range(0, 8)], $urandom, $urandom});
            q1.push_back('{LEGAL[$urandom_range(0, 8)], $urandom, $urandom});
        end
        run_pair();
        chk("t3_order_n", acc.size(), 4);
        for (int i = 0; i < acc.size(); i++) chk($sformatf("t3_grant%0d", i), acc[i], i % 2);
        drain();

        // Back-pressure: response held while respReady is low
        respReady = 1'b0;
        q0.push_back('{4'b0010, 32'd100, 32'd23});
        run_pair();
        cyc();
        cyc();
        reqValid0 = 1'b1; reqOpcode0 = 4'b0110; reqA0 = 32'd3; reqB0 = 32'd5;
        reqValid1 = 1'b1; reqOpcode1 = 4'b0100; reqA1 = 32'd3; reqB1 = 32'd5;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_valid_held", rv_seen, 1'b1);
            chk("bp_result_stable", res_seen, 32'd123);
            chk("bp_ready0_low", rr0, 1'b0);
            chk("bp_ready1_low", rr1, 1'b0);
            chk("bp_alu_idle_opcode", aop_seen, 4'b0000);
        end
        respReady = 1'b1;
        cyc();
        reqValid0 = 1'b0;
        reqValid1 = 1'b0;
        chk("bp_completed", sb.size(), 0);

        // Illegal opcode then a legal MOV
        q0.push_back('{4'b1111, 32'd0, 32'd9});
        q0.push_back('{4'b1101, 32'd7, 32'd3});
        run_pair();
        drain();

        // Reset asserted during CAPTURE drops the in-flight op
        q0.push_back('{4'b0010, 32'd1, 32'd2});
        run_pair();
        cyc();
        resetN = 1'b0;
        #1;
        chk("mr_busy", busy, 1'b0);
        chk("mr_respValid", respValid, 1'b0);
        chk("mr_aluOpcode", aluOpcode, 4'b0000);
        chk("mr_aluInOne", aluInOne, 32'd0);
        chk("mr_respResult", respResult, 32'd0);
        chk("mr_reqReady0", reqReady0, 1'b0);
        sb.delete();
        @(posedge clock);
        #1;
        resetN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("mr_no_resp", rv_seen, 1'b0);
        end
        q0.push_back('{4'b0100, 32'd12, 32'd3});
        q1.push_back('{4'b1100, 32'hF0F0, 32'h0FF0});
        run_pair();
        chk("mr_order_n", acc.size(), 2);
        if (acc.size() == 2) chk("mr_first_req0", acc[0], 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
